// File: rtl/regfile_dump.sv
// 32-entry dual-read, single-write register file with r0 hardwired to zero,
// plus a sequential dump engine that walks every register on a side port.
module regfile_dump #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic [4:0]       ReadRegister1,
  input  logic [4:0]       ReadRegister2,
  output logic [WIDTH-1:0] ReadData1,
  output logic [WIDTH-1:0] ReadData2,
  input  logic [4:0]       WriteRegister,
  input  logic [WIDTH-1:0] WriteData,
  input  logic             RegWrite,
  input  logic             DumpStart,
  output logic             DumpBusy,
  output logic             DumpValid,
  output logic [4:0]       DumpAddr,
  output logic [WIDTH-1:0] DumpData,
  output logic             DumpDone
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [WIDTH-1:0] regs [32];
  state_t           state, state_next;
  logic [4:0]       index, index_next;

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      regs <= '{default: '0};
    end else if (RegWrite && (WriteRegister != '0)) begin
      regs[WriteRegister] <= WriteData;
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [4:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if (addr != '0) begin
      if (BYPASS && RegWrite && (WriteRegister == addr))
        data = WriteData;
      else
        data = regs[addr];
    end
    return data;
  endfunction

  always_comb begin
    ReadData1 = read_port(ReadRegister1);
    ReadData2 = read_port(ReadRegister2);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      index <= '0;
    end else begin
      state <= state_next;
      index <= index_next;
    end
  end

  // Dump beats read stored contents only; bypass never applies to the dump port.
  always_comb begin
    state_next = state;
    index_next = index;
    DumpBusy   = 1'b0;
    DumpValid  = 1'b0;
    DumpAddr   = '0;
    DumpData   = '0;
    DumpDone   = 1'b0;
    unique case (state)
      IDLE: begin
        if (DumpStart) begin
          state_next = RUN;
          index_next = '0;
        end
      end
      RUN: begin
        DumpBusy   = 1'b1;
        DumpValid  = 1'b1;
        DumpAddr   = index;
        DumpData   = (index == '0) ? '0 : regs[index];
        index_next = index + 5'd1;
        if (index == 5'd31) state_next = DONE;
      end
      DONE: begin
        DumpBusy   = 1'b1;
        DumpDone   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump: read/write, r0, decoder, dump, async reset.
// A second instance with BYPASS=1 shares the inputs to check same-cycle forwarding.
module tb_regfile_dump;

  logic        Clk;
  logic        Reset_n;
  logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite, DumpStart;
  logic [31:0] ReadData1, ReadData2, DumpData;
  logic        DumpBusy, DumpValid, DumpDone;
  logic [4:0]  DumpAddr;
  logic [31:0] bp_rd1, bp_rd2, bp_dump_data;
  logic        bp_busy, bp_valid, bp_done;
  logic [4:0]  bp_dump_addr;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] model [32];

  regfile_dump #(.WIDTH(32), .BYPASS(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .DumpStart(DumpStart), .DumpBusy(DumpBusy), .DumpValid(DumpValid),
    .DumpAddr(DumpAddr), .DumpData(DumpData), .DumpDone(DumpDone)
  );

  regfile_dump #(.WIDTH(32), .BYPASS(1'b1)) dut_bp (
    .Clk(Clk), .Reset_n(Reset_n),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ReadData1(bp_rd1), .ReadData2(bp_rd2),
    .WriteRegister(WriteRegister), .WriteData(WriteData), .RegWrite(RegWrite),
    .DumpStart(DumpStart), .DumpBusy(bp_busy), .DumpValid(bp_valid),
    .DumpAddr(bp_dump_addr), .DumpData(bp_dump_data), .DumpDone(bp_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] data);
    @(negedge Clk);
    RegWrite = 1'b1; WriteRegister = addr; WriteData = data;
    @(negedge Clk);
    RegWrite = 1'b0;
    if (addr != 5'd0) model[addr] = data;
  endtask

  task automatic rd(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                    input logic [31:0] e1, input logic [31:0] e2);
    ReadRegister1 = a1; ReadRegister2 = a2;
    #1;
    check({tag, "_p1"}, ReadData1, e1);
    check({tag, "_p2"}, ReadData2, e2);
  endtask

  task automatic do_reset();
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    clear_model();
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(DumpBusy),  32'd0);
    check({tag, "_valid"}, 32'(DumpValid), 32'd0);
    check({tag, "_done"},  32'(DumpDone),  32'd0);
    check({tag, "_addr"},  32'(DumpAddr),  32'd0);
    check({tag, "_data"},  DumpData,       32'd0);
  endtask

  task automatic run_dump(input bit inject);
    @(negedge Clk) DumpStart = 1'b1;
    @(negedge Clk) DumpStart = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      check("beat_busy",  32'(DumpBusy),  32'd1);
      check("beat_valid", 32'(DumpValid), 32'd1);
      check("beat_done",  32'(DumpDone),  32'd0);
      check("beat_addr",  32'(DumpAddr),  32'(i));
      check("beat_data",  DumpData,       model[5'(i)]);
      if (inject && i == 3) DumpStart = 1'b1;
      if (inject && i == 4) DumpStart = 1'b0;
      if (inject && i == 5) begin
        RegWrite = 1'b1; WriteRegister = 5'd31; WriteData = 32'hDEADBEEF;
        model[31] = 32'hDEADBEEF;
      end
      if (inject && i == 6) RegWrite = 1'b0;
      @(negedge Clk);
    end
    #1;
    check("done_pulse", 32'(DumpDone),  32'd1);
    check("done_busy",  32'(DumpBusy),  32'd1);
    check("done_valid", 32'(DumpValid), 32'd0);
    @(negedge Clk); #1;
    check_idle_outputs("post_dump");
    @(negedge Clk); #1;
    check("no_requeue_busy", 32'(DumpBusy), 32'd0);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    clear_model();
    Reset_n = 1'b0;
    ReadRegister1 = 5'd5; ReadRegister2 = 5'd9;
    WriteRegister = '0; WriteData = '0; RegWrite = 1'b0; DumpStart = 1'b0;
    #2;
    check_idle_outputs("reset");
    check("reset_rd1", ReadData1, 32'd0);
    check("reset_rd2", ReadData2, 32'd0);
    @(negedge Clk) Reset_n = 1'b1;

    wr(5'd2, 32'd42);
    rd("r2_42", 5'd2, 5'd2, 32'd42, 32'd42);
    wr(5'd2, 32'd15);
    rd("r2_15", 5'd2, 5'd2, 32'd15, 32'd15);

    @(negedge Clk);
    RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'd15;
    rd("r0_wr", 5'd0, 5'd0, 32'd0, 32'd0);
    check("r0_bp_p1", bp_rd1, 32'd0);
    check("r0_bp_p2", bp_rd2, 32'd0);
    @(negedge Clk) RegWrite = 1'b0;
    rd("r0_after", 5'd0, 5'd0, 32'd0, 32'd0);

    @(negedge Clk);
    RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h77;
    rd("bypass_off", 5'd7, 5'd7, 32'd0, 32'd0);
    check("bypass_on_p1", bp_rd1, 32'h77);
    check("bypass_on_p2", bp_rd2, 32'h77);
    @(negedge Clk) RegWrite = 1'b0;
    model[7] = 32'h77;
    rd("bypass_after", 5'd7, 5'd7, 32'h77, 32'h77);

    wr(5'd2, 32'd42);
    @(negedge Clk);
    RegWrite = 1'b0; WriteRegister = 5'd2; WriteData = 32'd3;
    @(negedge Clk);
    rd("we_low", 5'd2, 5'd2, 32'd42, 32'd42);
    wr(5'd14, 32'd25);
    wr(5'd15, 32'd13);
    rd("r14_r15", 5'd14, 5'd15, 32'd25, 32'd13);

    do_reset();
    wr(5'd20, 32'd12);
    rd("dec_16_18", 5'd16, 5'd18, 32'd0, 32'd0);
    rd("dec_20", 5'd20, 5'd20, 32'd12, 32'd12);

    do_reset();
    for (int k = 1; k < 32; k++) begin
      wr(5'(k), 32'd1 << (k - 1));
      for (int j = 1; j < 32; j++)
        rd("walk", 5'(j), 5'(32 - j), model[5'(j)], model[5'(32 - j)]);
    end

    for (int k = 1; k < 32; k++) wr(5'(k), 32'(k) * 32'h01010101);
    run_dump(1'b0);
    run_dump(1'b1);
    rd("r31_beef", 5'd31, 5'd30, 32'hDEADBEEF, 32'd30 * 32'h01010101);

    @(negedge Clk) DumpStart = 1'b1;
    @(negedge Clk) DumpStart = 1'b0;
    repeat (10) @(negedge Clk);
    #1 check("beat10_addr", 32'(DumpAddr), 32'd10);
    #2 Reset_n = 1'b0;
    clear_model();
    #1;
    check_idle_outputs("async_rst");
    for (int j = 0; j < 32; j++)
      rd("async_regs", 5'(j), 5'(j), 32'd0, 32'd0);
    @(negedge Clk) Reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      check("post_rst_done", 32'(DumpDone), 32'd0);
      check("post_rst_busy", 32'(DumpBusy), 32'd0);
      @(negedge Clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
